// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2,
        StTrap = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response bus between the fetch stage and memory.
interface fetch_if;

    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_valid,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_valid,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// Single-entry pc/instr buffer that parks a response while decode is stalled.
module fetch_hold_buf (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    import fetch_pkg::*;

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // Flush and drain both empty the entry; load fills it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (flush_i || drain_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: pc, one-outstanding imem request, IF/ID register.
// Optional feature: FETCH_MISALIGN_TRAP_EN traps redirects with target bit 1 set.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_target_i,
    input  logic        stall_i,
    fetch_if.master     imem,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_trap_o,
    output logic [31:0] trap_addr_o
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         discard_q, discard_d;
    logic         bubble_q, bubble_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic         trap_q, trap_d;
    logic [31:0]  trap_addr_q, trap_addr_d;

    logic         buf_load, buf_drain, buf_flush, buf_valid;
    logic [31:0]  buf_pc, buf_instr;
    logic         accept;
    logic         misaligned;
    logic [31:0]  target;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = jump_target_i[1];
    assign target     = {jump_target_i[31:1], 1'b0};
`else
    logic unused_tgt_lo;
    assign unused_tgt_lo = ^jump_target_i[1:0] ^ trap_q ^ (|trap_addr_q) ^ buf_valid;
    assign misaligned    = 1'b0;
    assign target        = {jump_target_i[31:2], 2'b00};
`endif

    // Bubble keeps the request low for one cycle after an unaccepted redirect.
    assign imem.imem_valid = !rst_i && (state_q == StReq) && !bubble_q;
    assign imem.imem_addr  = pc_q;
    assign accept          = imem.imem_valid && imem.imem_ready;

    fetch_hold_buf u_hold_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (buf_load),
        .drain_i (buf_drain),
        .flush_i (buf_flush),
        .pc_i    (pc_q),
        .instr_i (imem.imem_rdata),
        .valid_o (buf_valid),
        .pc_o    (buf_pc),
        .instr_o (buf_instr)
    );

    // Next-state: normal progress first, then redirect overrides it.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        bubble_d    = 1'b0;
        id_valid_d  = stall_i ? id_valid_q : 1'b0;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;
        trap_d      = 1'b0;
        trap_addr_d = trap_addr_q;
        buf_load    = 1'b0;
        buf_drain   = 1'b0;
        buf_flush   = 1'b0;

        unique case (state_q)
            StReq: begin
                if (accept) state_d = StWait;
            end
            StWait: begin
                if (imem.imem_rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end else if (!stall_i) begin
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_q;
                        id_instr_d = imem.imem_rdata;
                        pc_d       = pc_q + 32'd4;
                        state_d    = StReq;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = StHold;
                    end
                end
            end
            StHold: begin
                if (!stall_i) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = buf_pc;
                    id_instr_d = buf_instr;
                    buf_drain  = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    state_d    = StReq;
                end
            end
            StTrap: begin
            end
            default: state_d = StReq;
        endcase

        if (jump_flag_i && (state_q != StTrap)) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            buf_flush  = 1'b1;
            buf_load   = 1'b0;
            buf_drain  = 1'b0;
            if (misaligned) begin
                trap_d      = 1'b1;
                trap_addr_d = jump_target_i;
                discard_d   = 1'b0;
                state_d     = StTrap;
            end else begin
                pc_d = target;
                unique case (state_q)
                    StReq: begin
                        if (accept) begin
                            discard_d = 1'b1;
                            state_d   = StWait;
                        end else begin
                            bubble_d = 1'b1;
                            state_d  = StReq;
                        end
                    end
                    StWait: begin
                        // A coincident response is the wrong-path word: drop it.
                        discard_d = !imem.imem_rvalid;
                        state_d   = imem.imem_rvalid ? StReq : StWait;
                    end
                    default: state_d = StReq;
                endcase
            end
        end
    end

    // State and IF/ID register update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StReq;
            pc_q        <= RESET_PC;
            discard_q   <= 1'b0;
            bubble_q    <= 1'b0;
            id_valid_q  <= 1'b0;
            id_pc_q     <= '0;
            id_instr_q  <= NOP_INSTR;
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            discard_q   <= discard_d;
            bubble_q    <= bubble_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_instr_q  <= id_instr_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign id_valid_o = id_valid_q;
    assign id_pc_o    = id_pc_q;
    assign id_instr_o = id_instr_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_trap_o = trap_q;
    assign trap_addr_o     = trap_addr_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_trap;
    logic [31:0] trap_addr;
`endif

    int checks = 0;
    int errors = 0;

    fetch_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .jump_flag_i   (jump_flag),
        .jump_target_i (jump_target),
        .stall_i       (stall),
        .imem          (imem_bus.master),
        .id_valid_o    (id_valid),
        .id_pc_o       (id_pc),
        .id_instr_o    (id_instr)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_trap_o (misalign_trap),
        .trap_addr_o     (trap_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; jump_flag = 1'b0; jump_target = '0; stall = 1'b0;
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
        step(); step();
        chk("rst_valid", {31'd0, imem_bus.imem_valid}, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0000_0013);

        // First fetch at RESET_PC, zero-wait memory.
        rst = 1'b0; imem_bus.imem_ready = 1'b1;
        #1;
        chk("req0_valid", {31'd0, imem_bus.imem_valid}, 32'd1);
        chk("req0_addr", imem_bus.imem_addr, 32'h100);
        step();
        imem_bus.imem_ready = 1'b0; imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata = 32'h0050_0093;
        chk("wait0_valid", {31'd0, imem_bus.imem_valid}, 32'd0);
        step();
        imem_bus.imem_rvalid = 1'b0;
        chk("ld0_id_valid", {31'd0, id_valid}, 32'd1);
        chk("ld0_id_pc", id_pc, 32'h100);
        chk("ld0_id_instr", id_instr, 32'h0050_0093);
        chk("req1_valid", {31'd0, imem_bus.imem_valid}, 32'd1);
        chk("req1_addr", imem_bus.imem_addr, 32'h104);

        // Memory not ready for 3 cycles: address held.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nrdy_addr", imem_bus.imem_addr, 32'h104);
            chk("nrdy_valid", {31'd0, imem_bus.imem_valid}, 32'd1);
        end
        chk("nrdy_id_valid", {31'd0, id_valid}, 32'd0);
        imem_bus.imem_ready = 1'b1;
        step();
        imem_bus.imem_ready = 1'b0;
        chk("acc1_valid", {31'd0, imem_bus.imem_valid}, 32'd0);

        // Response arrives under stall; released two cycles later.
        stall = 1'b1; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_bus.imem_rvalid = 1'b0;
        chk("stl_id_instr0", id_instr, 32'h0050_0093);
        chk("stl_id_valid0", {31'd0, id_valid}, 32'd0);
        chk("stl_valid0", {31'd0, imem_bus.imem_valid}, 32'd0);
        step();
        chk("stl_id_instr1", id_instr, 32'h0050_0093);
        stall = 1'b0;
        step();
        chk("rel_id_valid", {31'd0, id_valid}, 32'd1);
        chk("rel_id_instr", id_instr, 32'hDEAD_BEEF);
        chk("rel_id_pc", id_pc, 32'h104);
        chk("req2_addr", imem_bus.imem_addr, 32'h108);

        // Redirect while waiting: pending response is dropped.
        imem_bus.imem_ready = 1'b1;
        step();
        imem_bus.imem_ready = 1'b0;
        jump_flag = 1'b1; jump_target = 32'h200;
        step();
        jump_flag = 1'b0;
        chk("jw_id_valid", {31'd0, id_valid}, 32'd0);
        chk("jw_id_instr", id_instr, 32'h0000_0013);
        chk("jw_valid", {31'd0, imem_bus.imem_valid}, 32'd0);
        imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h1234_5678;
        step();
        imem_bus.imem_rvalid = 1'b0;
        chk("jw_drop_instr", id_instr, 32'h0000_0013);
        chk("jw_drop_valid", {31'd0, id_valid}, 32'd0);
        chk("jw_req_valid", {31'd0, imem_bus.imem_valid}, 32'd1);
        chk("jw_req_addr", imem_bus.imem_addr, 32'h200);

        // Redirect with stall in hold: buffer dropped, bit 0 cleared.
        imem_bus.imem_ready = 1'b1;
        step();
        imem_bus.imem_ready = 1'b0;
        stall = 1'b1; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'hCAFE_F00D;
        step();
        imem_bus.imem_rvalid = 1'b0;
        jump_flag = 1'b1; jump_target = 32'h301;
        step();
        jump_flag = 1'b0;
        chk("jh_valid", {31'd0, imem_bus.imem_valid}, 32'd1);
        chk("jh_addr", imem_bus.imem_addr, 32'h300);
        chk("jh_id_instr", id_instr, 32'h0000_0013);
        stall = 1'b0;
        step();
        chk("jh_nobuf_valid", {31'd0, id_valid}, 32'd0);
        chk("jh_nobuf_instr", id_instr, 32'h0000_0013);
        chk("jh_addr_hold", imem_bus.imem_addr, 32'h300);

        // Redirect in S_REQ not accepted: one-cycle bubble, then target.
        jump_flag = 1'b1; jump_target = 32'h400;
        step();
        jump_flag = 1'b0;
        chk("jr_bubble", {31'd0, imem_bus.imem_valid}, 32'd0);
        step();
        chk("jr_valid", {31'd0, imem_bus.imem_valid}, 32'd1);
        chk("jr_addr", imem_bus.imem_addr, 32'h400);

        // Reset mid-transaction; late response ignored.
        imem_bus.imem_ready = 1'b1;
        step();
        imem_bus.imem_ready = 1'b0; rst = 1'b1;
        step();
        chk("mrst_valid", {31'd0, imem_bus.imem_valid}, 32'd0);
        rst = 1'b0; imem_bus.imem_rvalid = 1'b1; imem_bus.imem_rdata = 32'h1111_1111;
        #1;
        chk("mrst_addr", imem_bus.imem_addr, 32'h100);
        step();
        imem_bus.imem_rvalid = 1'b0;
        chk("late_id_valid", {31'd0, id_valid}, 32'd0);
        chk("late_req_valid", {31'd0, imem_bus.imem_valid}, 32'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
        jump_flag = 1'b1; jump_target = 32'h202;
        step();
        jump_flag = 1'b0;
        chk("trap_pulse", {31'd0, misalign_trap}, 32'd1);
        chk("trap_addr", trap_addr, 32'h202);
        chk("trap_valid0", {31'd0, imem_bus.imem_valid}, 32'd0);
        imem_bus.imem_ready = 1'b1;
        step();
        chk("trap_pulse_end", {31'd0, misalign_trap}, 32'd0);
        step();
        chk("trap_valid2", {31'd0, imem_bus.imem_valid}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
